// File: rtl/alarm_trigger_ctrl_pkg.sv
// Shared types and constants for the alarm trigger controller.
// Imported by the interface, the tone generator and the top.
package alarm_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RINGING,
        SNOOZE,
        DISMISSED
    } state_t;

    localparam int HH_W   = 5;
    localparam int MM_W   = 6;
    localparam int TONE_W = 24;

    localparam logic [TONE_W-1:0] DEF_PATTERN = 24'hF0F0F0;

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/alarm_trigger_ctrl_if.sv
// Signal bundle between time/button logic, the alarm controller
// and the buzzer driver.
interface alarm_trigger_ctrl_if
    import alarm_pkg::*;
#(
    parameter int MAX_SNOOZE = 3
);

    localparam int CNT_W = $clog2(MAX_SNOOZE + 1);

    logic              tick_1hz;
    logic [HH_W-1:0]   cur_hh;
    logic [MM_W-1:0]   cur_mm;
    logic [HH_W-1:0]   alarm_hh;
    logic [MM_W-1:0]   alarm_mm;
    logic              alarm_en;
    logic              snooze_btn;
    logic              dismiss_btn;
    logic              alarmActive;
    logic [TONE_W-1:0] toneBus;
    logic              snoozing;
    logic [CNT_W-1:0]  snooze_count;

    modport master (
        output tick_1hz, cur_hh, cur_mm,
        output alarm_hh, alarm_mm, alarm_en,
        output snooze_btn, dismiss_btn,
        input  alarmActive, toneBus,
        input  snoozing, snooze_count
    );

    modport slave (
        input  tick_1hz, cur_hh, cur_mm,
        input  alarm_hh, alarm_mm, alarm_en,
        input  snooze_btn, dismiss_btn,
        output alarmActive, toneBus,
        output snoozing, snooze_count
    );

endinterface

// File: rtl/alarm_trigger_ctrl_tone_pattern_gen.sv
// Beep pattern register: reloads on ring entry, rotates right
// once per PATTERN_DIV clocks while running, zero otherwise.
module tone_pattern_gen
    import alarm_pkg::*;
#(
    parameter int                PATTERN_DIV = 12_500_000,
    parameter logic [TONE_W-1:0] PATTERN     = DEF_PATTERN
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              run,
    output logic [TONE_W-1:0] toneBus
);

    localparam int DIV_W =
        (PATTERN_DIV > 1) ? $clog2(PATTERN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST =
        DIV_W'(PATTERN_DIV - 1);

    logic [DIV_W-1:0]  r_div;
    logic [TONE_W-1:0] r_tone;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div  <= '0;
            r_tone <= '0;
        end else if (load) begin
            r_div  <= '0;
            r_tone <= PATTERN;
        end else if (run) begin
            if (r_div == DIV_LAST) begin
                r_div  <= '0;
                r_tone <= {r_tone[0], r_tone[TONE_W-1:1]};
            end else begin
                r_div <= r_div + 1'b1;
            end
        end else begin
            r_div  <= '0;
            r_tone <= '0;
        end
    end

    assign toneBus = r_tone;

endmodule

// File: rtl/alarm_trigger_ctrl.sv
// Alarm trigger: time compare, ring/snooze/dismiss FSM,
// auto-timeout and snooze accounting; feeds the buzzer driver.
module alarm_trigger_ctrl
    import alarm_pkg::*;
#(
    parameter int                PATTERN_DIV  = 12_500_000,
    parameter int                RING_MAX_SEC = 60,
    parameter int                SNOOZE_SEC   = 300,
    parameter int                MAX_SNOOZE   = 3,
    parameter logic [TONE_W-1:0] PATTERN      = DEF_PATTERN
) (
    input  logic                 clk,
    input  logic                 rst_n,
    alarm_trigger_ctrl_if.slave  bus
);

    localparam int SEC_MAX = imax(RING_MAX_SEC, SNOOZE_SEC);
    localparam int SEC_W   = $clog2(SEC_MAX + 1);
    localparam int CNT_W   = $clog2(MAX_SNOOZE + 1);

    localparam logic [SEC_W-1:0] RING_LAST =
        SEC_W'(RING_MAX_SEC - 1);
    localparam logic [SEC_W-1:0] SNZ_LAST =
        SEC_W'(SNOOZE_SEC - 1);
    localparam logic [CNT_W-1:0] CNT_MAX =
        CNT_W'(MAX_SNOOZE);

    state_t           r_state;
    state_t           w_next;
    logic [SEC_W-1:0] r_sec;
    logic [SEC_W-1:0] w_sec;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt;
    logic             r_snz_d;
    logic             r_dis_d;
    logic             r_active;
    logic             r_snoozing;

    logic w_match;
    logic w_tick;
    logic w_snz_rise;
    logic w_dis_rise;
    logic w_kill;
    logic w_load;
    logic w_run;

    assign w_tick  = bus.tick_1hz;
    assign w_match = bus.alarm_en
                   & (bus.cur_hh == bus.alarm_hh)
                   & (bus.cur_mm == bus.alarm_mm);

    assign w_snz_rise = bus.snooze_btn  & ~r_snz_d;
    assign w_dis_rise = bus.dismiss_btn & ~r_dis_d;

    // Disarm behaves like a dismiss press from any active state.
    assign w_kill = ~bus.alarm_en | w_dis_rise;

    always_comb begin
        w_next = r_state;
        w_sec  = r_sec;
        w_cnt  = r_cnt;
        unique case (r_state)
            IDLE: begin
                if (w_tick & w_match) begin
                    w_next = RINGING;
                    w_sec  = '0;
                    w_cnt  = '0;
                end
            end
            RINGING: begin
                if (w_kill) begin
                    w_next = DISMISSED;
                    w_sec  = '0;
                end else if (w_snz_rise & (r_cnt < CNT_MAX)) begin
                    w_next = SNOOZE;
                    w_cnt  = r_cnt + 1'b1;
                    w_sec  = '0;
                end else if (w_tick) begin
                    if (r_sec == RING_LAST) begin
                        w_next = DISMISSED;
                        w_sec  = '0;
                    end else begin
                        w_sec = r_sec + 1'b1;
                    end
                end
            end
            SNOOZE: begin
                if (w_kill) begin
                    w_next = DISMISSED;
                    w_sec  = '0;
                end else if (w_tick) begin
                    if (r_sec == SNZ_LAST) begin
                        w_next = RINGING;
                        w_sec  = '0;
                    end else begin
                        w_sec = r_sec + 1'b1;
                    end
                end
            end
            DISMISSED: begin
                // Wait out the matching minute so it cannot retrigger.
                if (w_tick & ~w_match) begin
                    w_next = IDLE;
                    w_sec  = '0;
                    w_cnt  = '0;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_sec      <= '0;
            r_cnt      <= '0;
            r_snz_d    <= 1'b0;
            r_dis_d    <= 1'b0;
            r_active   <= 1'b0;
            r_snoozing <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_sec      <= w_sec;
            r_cnt      <= w_cnt;
            r_snz_d    <= bus.snooze_btn;
            r_dis_d    <= bus.dismiss_btn;
            r_active   <= (w_next == RINGING);
            r_snoozing <= (w_next == SNOOZE);
        end
    end

    assign w_run  = (w_next == RINGING);
    assign w_load = w_run & (r_state != RINGING);

    tone_pattern_gen #(
        .PATTERN_DIV (PATTERN_DIV),
        .PATTERN     (PATTERN)
    ) u_tone (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (w_load),
        .run     (w_run),
        .toneBus (bus.toneBus)
    );

    assign bus.alarmActive  = r_active;
    assign bus.snoozing     = r_snoozing;
    assign bus.snooze_count = r_cnt;

endmodule
